// File: rtl/bcd_timer_if.sv
// bcd_timer_if: control and status bundle for bcd_timer.
//   master drives : load, load_value, start, pause, up_down
//   slave drives  : count, tc, step, expired, running
// DIGITS must match the DIGITS of the attached bcd_timer.
interface bcd_timer_if #(
  parameter int unsigned DIGITS = 3
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  pause;
  logic                  up_down;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  step;
  logic                  expired;
  logic                  running;

  // Controller side.
  modport master (
    output load, load_value, start, pause, up_down,
    input  count, tc, step, expired, running
  );

  // Timer side.
  modport slave (
    input  load, load_value, start, pause, up_down,
    output count, tc, step, expired, running
  );

endinterface

// File: rtl/bcd_timer.sv
// bcd_timer: multi-digit packed-BCD up/down timer with a prescaler.
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   tmr.load       (in)  : preset count from load_value (digits > 9 clamp to 9), go IDLE
//   tmr.load_value (in)  : packed BCD preset, digit 0 in bits [3:0]
//   tmr.start      (in)  : begin/resume counting from IDLE or PAUSE
//   tmr.pause      (in)  : suspend counting while in RUN
//   tmr.up_down    (in)  : 1 = count up, 0 = count down, sampled at each step
//   tmr.count      (out) : registered packed BCD value
//   tmr.tc         (out) : combinational, high when count is all zeros
//   tmr.step       (out) : one-cycle pulse with each newly stepped count
//   tmr.expired    (out) : one-cycle pulse on entry to DONE
//   tmr.running    (out) : high only in RUN
module bcd_timer #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          WRAP     = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  bcd_timer_if.slave    tmr
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [W-1:0]  NINES      = {DIGITS{4'h9}};
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            step_q, step_d;
  logic            expired_q, expired_d;
  logic            running_q, running_d;

  logic [W-1:0]    terminal;
  logic [W-1:0]    stepped;
  logic            at_term;

  // Clamp every non-decimal digit of a preset to 9.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // BCD decrement with borrow ripple; 0..0 rolls to 9..9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD increment with carry ripple; 9..9 rolls to 0..0.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // State, count, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      step_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

  // Next-state, next-count and pulse generation.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    step_d    = 1'b0;
    expired_d = 1'b0;
    running_d = 1'b0;

    terminal = tmr.up_down ? NINES : '0;
    at_term  = (count_q == terminal);
    stepped  = tmr.up_down ? bcd_inc(count_q) : bcd_dec(count_q);

    if (tmr.load) begin
      count_d = bcd_sat(tmr.load_value);
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        // pause has no effect outside RUN, so it does not mask start here.
        IDLE, PAUSE: begin
          if (tmr.start) begin
            if (!WRAP && at_term) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end

        RUN: begin
          if (tmr.pause) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            // Direction flipped onto an already-terminal count: stop rather than roll over.
            if (!WRAP && at_term) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              count_d = stepped;
              step_d  = 1'b1;
              if (!WRAP && (stepped == terminal)) begin
                state_d   = DONE;
                expired_d = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  assign tmr.count   = count_q;
  assign tmr.tc      = (count_q == '0);
  assign tmr.step    = step_q;
  assign tmr.expired = expired_q;
  assign tmr.running = running_q;

endmodule

// File: tb/tb_bcd_timer.sv
// tb_bcd_timer: directed bench for bcd_timer, DIGITS=3, TICK_DIV=4.
// dut0 runs with WRAP=0, dut1 with WRAP=1; both share clk and reset.
module tb_bcd_timer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  bcd_timer_if #(.DIGITS(3)) bus0 ();
  bcd_timer_if #(.DIGITS(3)) bus1 ();

  bcd_timer #(.DIGITS(3), .TICK_DIV(4), .WRAP(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .tmr   (bus0)
  );

  bcd_timer #(.DIGITS(3), .TICK_DIV(4), .WRAP(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .tmr   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load0(input logic [11:0] v);
    bus0.load = 1'b1; bus0.load_value = v;
    tick(1);
    bus0.load = 1'b0;
  endtask

  task automatic start0(input logic dir);
    bus0.up_down = dir; bus0.start = 1'b1;
    tick(1);
    bus0.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus0.load = 1'b1; bus0.load_value = 12'h555; bus0.start = 1'b1;
    tick(2);
    n_cmp++; if (bus0.count !== 12'h000) begin n_err++; $display("FAIL reset_count: got %h want 000", bus0.count); end
    n_cmp++; if (bus0.tc !== 1'b1) begin n_err++; $display("FAIL reset_tc: got %b want 1", bus0.tc); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", bus0.running); end
    n_cmp++; if (bus0.step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %b want 0", bus0.step); end
    n_cmp++; if (bus0.expired !== 1'b0) begin n_err++; $display("FAIL reset_expired: got %b want 0", bus0.expired); end
    n_cmp++; if (bus1.count !== 12'h000) begin n_err++; $display("FAIL reset_count1: got %h want 000", bus1.count); end
    reset = 1'b0; bus0.load = 1'b0; bus0.start = 1'b0;
    tick(1);
  endtask

  task automatic test_count_down;
    load0(12'h101);
    start0(1'b0);
    n_cmp++; if (bus0.running !== 1'b1) begin n_err++; $display("FAIL down_running: got %b want 1", bus0.running); end
    tick(3);
    n_cmp++; if (bus0.count !== 12'h101) begin n_err++; $display("FAIL down_hold: got %h want 101", bus0.count); end
    n_cmp++; if (bus0.step !== 1'b0) begin n_err++; $display("FAIL down_nostep: got %b want 0", bus0.step); end
    tick(1);
    n_cmp++; if (bus0.count !== 12'h100) begin n_err++; $display("FAIL down_first: got %h want 100", bus0.count); end
    n_cmp++; if (bus0.step !== 1'b1) begin n_err++; $display("FAIL down_step1: got %b want 1", bus0.step); end
    tick(1);
    n_cmp++; if (bus0.step !== 1'b0) begin n_err++; $display("FAIL down_step_pulse: got %b want 0", bus0.step); end
    tick(2);
    n_cmp++; if (bus0.count !== 12'h100) begin n_err++; $display("FAIL down_hold2: got %h want 100", bus0.count); end
    tick(1);
    n_cmp++; if (bus0.count !== 12'h099) begin n_err++; $display("FAIL down_borrow: got %h want 099", bus0.count); end
    n_cmp++; if (bus0.step !== 1'b1) begin n_err++; $display("FAIL down_step2: got %b want 1", bus0.step); end
  endtask

  task automatic test_expire;
    load0(12'h002);
    start0(1'b0);
    tick(4);
    n_cmp++; if (bus0.count !== 12'h001) begin n_err++; $display("FAIL exp_first: got %h want 001", bus0.count); end
    n_cmp++; if (bus0.expired !== 1'b0) begin n_err++; $display("FAIL exp_early: got %b want 0", bus0.expired); end
    tick(4);
    n_cmp++; if (bus0.count !== 12'h000) begin n_err++; $display("FAIL exp_zero: got %h want 000", bus0.count); end
    n_cmp++; if (bus0.expired !== 1'b1) begin n_err++; $display("FAIL exp_pulse: got %b want 1", bus0.expired); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL exp_running: got %b want 0", bus0.running); end
    n_cmp++; if (bus0.tc !== 1'b1) begin n_err++; $display("FAIL exp_tc: got %b want 1", bus0.tc); end
    tick(1);
    n_cmp++; if (bus0.expired !== 1'b0) begin n_err++; $display("FAIL exp_once: got %b want 0", bus0.expired); end
    start0(1'b0);
    tick(4);
    n_cmp++; if (bus0.count !== 12'h000) begin n_err++; $display("FAIL done_hold: got %h want 000", bus0.count); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL done_start_ignored: got %b want 0", bus0.running); end
    n_cmp++; if (bus0.expired !== 1'b0) begin n_err++; $display("FAIL done_no_reexpire: got %b want 0", bus0.expired); end
  endtask

  task automatic test_up_carry;
    load0(12'h099);
    start0(1'b1);
    tick(4);
    n_cmp++; if (bus0.count !== 12'h100) begin n_err++; $display("FAIL up_carry: got %h want 100", bus0.count); end
    n_cmp++; if (bus0.tc !== 1'b0) begin n_err++; $display("FAIL up_tc: got %b want 0", bus0.tc); end
    n_cmp++; if (bus0.step !== 1'b1) begin n_err++; $display("FAIL up_step: got %b want 1", bus0.step); end
    load0(12'h000);
  endtask

  task automatic test_terminal_start;
    load0(12'h999);
    start0(1'b1);
    n_cmp++; if (bus0.expired !== 1'b1) begin n_err++; $display("FAIL term_expired: got %b want 1", bus0.expired); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL term_running: got %b want 0", bus0.running); end
    n_cmp++; if (bus0.step !== 1'b0) begin n_err++; $display("FAIL term_step: got %b want 0", bus0.step); end
    n_cmp++; if (bus0.count !== 12'h999) begin n_err++; $display("FAIL term_count: got %h want 999", bus0.count); end
    bus0.up_down = 1'b0;
  endtask

  task automatic test_pause;
    load0(12'h050);
    start0(1'b0);
    tick(2);
    bus0.pause = 1'b1;
    tick(1);
    bus0.pause = 1'b0;
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want 0", bus0.running); end
    tick(4);
    n_cmp++; if (bus0.count !== 12'h050) begin n_err++; $display("FAIL pause_hold: got %h want 050", bus0.count); end
    start0(1'b0);
    n_cmp++; if (bus0.running !== 1'b1) begin n_err++; $display("FAIL resume_running: got %b want 1", bus0.running); end
    tick(1);
    n_cmp++; if (bus0.count !== 12'h050) begin n_err++; $display("FAIL resume_early: got %h want 050", bus0.count); end
    tick(1);
    n_cmp++; if (bus0.count !== 12'h049) begin n_err++; $display("FAIL resume_step: got %h want 049", bus0.count); end
    n_cmp++; if (bus0.step !== 1'b1) begin n_err++; $display("FAIL resume_step_pulse: got %b want 1", bus0.step); end
  endtask

  task automatic test_load_sat;
    bus0.load = 1'b1; bus0.load_value = 12'h1A5; bus0.start = 1'b1;
    tick(1);
    bus0.load = 1'b0; bus0.start = 1'b0;
    n_cmp++; if (bus0.count !== 12'h195) begin n_err++; $display("FAIL sat_count: got %h want 195", bus0.count); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL sat_running: got %b want 0", bus0.running); end
    tick(1);
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL sat_idle: got %b want 0", bus0.running); end
    start0(1'b0);
    n_cmp++; if (bus0.running !== 1'b1) begin n_err++; $display("FAIL sat_start: got %b want 1", bus0.running); end
  endtask

  task automatic test_reset_mid_run;
    load0(12'h500);
    start0(1'b0);
    tick(5);
    n_cmp++; if (bus0.count !== 12'h499) begin n_err++; $display("FAIL mid_pre: got %h want 499", bus0.count); end
    reset = 1'b1; bus0.start = 1'b1;
    tick(1);
    reset = 1'b0; bus0.start = 1'b0;
    n_cmp++; if (bus0.count !== 12'h000) begin n_err++; $display("FAIL mid_count: got %h want 000", bus0.count); end
    n_cmp++; if (bus0.running !== 1'b0) begin n_err++; $display("FAIL mid_running: got %b want 0", bus0.running); end
    n_cmp++; if (bus0.tc !== 1'b1) begin n_err++; $display("FAIL mid_tc: got %b want 1", bus0.tc); end
  endtask

  task automatic test_wrap;
    logic exp_seen;
    exp_seen = 1'b0;
    bus1.load = 1'b1; bus1.load_value = 12'h000;
    tick(1);
    bus1.load = 1'b0; bus1.up_down = 1'b0; bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus1.expired) exp_seen = 1'b1;
    end
    n_cmp++; if (bus1.count !== 12'h999) begin n_err++; $display("FAIL wrap_down: got %h want 999", bus1.count); end
    n_cmp++; if (bus1.running !== 1'b1) begin n_err++; $display("FAIL wrap_running: got %b want 1", bus1.running); end
    bus1.load = 1'b1; bus1.load_value = 12'h999;
    tick(1);
    bus1.load = 1'b0; bus1.up_down = 1'b1; bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus1.expired) exp_seen = 1'b1;
    end
    n_cmp++; if (bus1.count !== 12'h000) begin n_err++; $display("FAIL wrap_up: got %h want 000", bus1.count); end
    n_cmp++; if (bus1.step !== 1'b1) begin n_err++; $display("FAIL wrap_step: got %b want 1", bus1.step); end
    n_cmp++; if (exp_seen !== 1'b0) begin n_err++; $display("FAIL wrap_expired: got %b want 0", exp_seen); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus0.load = 1'b0; bus0.load_value = '0; bus0.start = 1'b0; bus0.pause = 1'b0; bus0.up_down = 1'b0;
    bus1.load = 1'b0; bus1.load_value = '0; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.up_down = 1'b0;
    test_reset;
    test_count_down;
    test_expire;
    test_up_carry;
    test_terminal_start;
    test_pause;
    test_load_sat;
    test_reset_mid_run;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
